mem_access: RTL and testbench

Memory-access stage of the 5-stage RISC-V pipeline, between the EX/MEM pipeline register and `mem_wb`. It issues load/store requests to the data bus through a req/ack handshake and formats load data (byte lane select, sign/zero extension). It produces the `rd` value, write-enable and address that `mem_wb` captures. Non-memory instructions pass through combinationally. Memory instructions stall the upstream pipeline until the bus transaction completes or times out.

---
 rtl/mem_access_pkg.sv | 43 ++++
 rtl/mem_lsu_align.sv | 50 +++++
 rtl/mem_access.sv | 178 +++++++++++++++++
 tb/tb_mem_access.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared configuration for the memory-access stage: widths, funct3 codes and FSM states.
// The optional misaligned-access trap is compiled in when MEM_MISALIGN_EXC_EN is defined.
package mem_access_pkg;

    localparam int unsigned XLEN_DEF       = 32;
    localparam int unsigned XREG_ADDRWIDTH = 5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Unsigned variants only exist for loads.
    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = is_load;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_H, F3_HU: bad = lo[0];
            F3_W:        bad = |lo;
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: store data replication / byte enables and load lane
// extraction with sign or zero extension. Low address bits are force-aligned by size.
module mem_lsu_align
    import mem_access_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [2:0]      st_funct3,
    input  logic [1:0]      st_addr_lo,
    input  logic [XLEN-1:0] st_data,
    output logic [XLEN-1:0] st_wdata,
    output logic [3:0]      st_be,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_addr_lo,
    input  logic [XLEN-1:0] ld_word,
    output logic [XLEN-1:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_wdata = st_data;
        st_be    = 4'b1111;
        case (st_funct3)
            F3_B: begin
                st_wdata = {4{st_data[7:0]}};
                st_be    = 4'b0001 << st_addr_lo;
            end
            F3_H: begin
                st_wdata = {2{st_data[15:0]}};
                st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = ld_word[{ld_addr_lo, 3'b000} +: 8];
        ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'b0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'b0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: req/ack data-bus master with timeout, load formatting
// and pass-through of non-memory results. MEM_MISALIGN_EXC_EN adds the misalign_exc trap.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_in,
    input  logic                      mem_rd_in,
    input  logic                      mem_wr_in,
    input  logic [2:0]                funct3_in,
    input  logic [XLEN-1:0]           addr_in,
    input  logic [XLEN-1:0]           wdata_in,
    input  logic [XLEN-1:0]           rd_in,
    input  logic                      rd_en_in,
    input  logic [XREG_ADDRWIDTH-1:0] rd_addr_in,
    output logic                      dbus_req,
    output logic                      dbus_we,
    output logic [XLEN-1:0]           dbus_addr,
    output logic [XLEN-1:0]           dbus_wdata,
    output logic [3:0]                dbus_be,
    input  logic                      dbus_ack,
    input  logic [XLEN-1:0]           dbus_rdata,
    output logic [XLEN-1:0]           rd_out,
    output logic                      rd_en_out,
    output logic [XREG_ADDRWIDTH-1:0] rd_addr_out,
    output logic                      stall_req,
    output logic                      bus_err
`ifdef MEM_MISALIGN_EXC_EN
    ,
    output logic                      misalign_exc
`endif
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t                      state_q, state_d;
    logic [7:0]                  cnt_q;
    logic                        is_load_q;
    logic [2:0]                  f3_q;
    logic [1:0]                  lo_q;
    logic [XREG_ADDRWIDTH-1:0]   rd_addr_q;
    logic                        err_q;
    logic [XLEN-1:0]             result_q;

    logic                        mem_op, legal, misal, accept;
    logic [XLEN-1:0]             st_wdata, ld_data;
    logic [3:0]                  st_be;

    mem_lsu_align #(.XLEN(XLEN)) u_align (
        .st_funct3  (funct3_in),
        .st_addr_lo (addr_in[1:0]),
        .st_data    (wdata_in),
        .st_wdata   (st_wdata),
        .st_be      (st_be),
        .ld_funct3  (f3_q),
        .ld_addr_lo (lo_q),
        .ld_word    (dbus_rdata),
        .ld_data    (ld_data)
    );

    assign mem_op = valid_in && (mem_rd_in || mem_wr_in);
    assign legal  = f3_legal(mem_rd_in, funct3_in);
`ifdef MEM_MISALIGN_EXC_EN
    assign misal  = misaligned(funct3_in, addr_in[1:0]);
`else
    assign misal  = 1'b0;
`endif
    assign accept = (state_q == IDLE) && mem_op && legal && !misal;

    always_comb begin
        state_d     = state_q;
        rd_out      = rd_in;
        rd_en_out   = rd_en_in;
        rd_addr_out = rd_addr_in;
        stall_req   = 1'b0;
        bus_err     = 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
        misalign_exc = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    rd_en_out = 1'b0;
                    if (accept) begin
                        stall_req = 1'b1;
                        state_d   = REQ;
                    end
`ifdef MEM_MISALIGN_EXC_EN
                    else if (legal) begin
                        misalign_exc = 1'b1;
                    end
`endif
                end
            end
            REQ: begin
                stall_req = 1'b1;
                rd_en_out = 1'b0;
                if (dbus_ack || cnt_q == TMO_LAST) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rd_out      = result_q;
                rd_en_out   = is_load_q && !err_q;
                rd_addr_out = rd_addr_q;
                bus_err     = err_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // The pass-through paths are combinational, so reset must mask them too.
        if (!rst) begin
            rd_out      = '0;
            rd_en_out   = 1'b0;
            rd_addr_out = '0;
            stall_req   = 1'b0;
            bus_err     = 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
            misalign_exc = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_load_q  <= 1'b0;
            f3_q       <= '0;
            lo_q       <= '0;
            rd_addr_q  <= '0;
            err_q      <= 1'b0;
            result_q   <= '0;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_wdata <= '0;
            dbus_be    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    err_q <= 1'b0;
                    if (accept) begin
                        is_load_q  <= mem_rd_in;
                        f3_q       <= funct3_in;
                        lo_q       <= addr_in[1:0];
                        rd_addr_q  <= rd_addr_in;
                        dbus_req   <= 1'b1;
                        dbus_we    <= mem_wr_in;
                        dbus_addr  <= {addr_in[XLEN-1:2], 2'b00};
                        dbus_wdata <= mem_wr_in ? st_wdata : '0;
                        dbus_be    <= mem_wr_in ? st_be : 4'b1111;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (dbus_ack) begin
                        dbus_req <= 1'b0;
                        if (is_load_q) begin
                            result_q <= ld_data;
                        end
                    end else if (cnt_q == TMO_LAST) begin
                        dbus_req <= 1'b0;
                        err_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized loads/stores
// against a size/lane arithmetic model. Exercises misalign_exc when MEM_MISALIGN_EXC_EN is set.
module tb_mem_access;

    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_in = 1'b0, mem_rd_in = 1'b0, mem_wr_in = 1'b0;
    logic [2:0]  funct3_in = '0;
    logic [31:0] addr_in = '0, wdata_in = '0, rd_in = '0;
    logic        rd_en_in = 1'b0;
    logic [4:0]  rd_addr_in = '0;
    logic        dbus_req, dbus_we, dbus_ack = 1'b0;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata = '0;
    logic [3:0]  dbus_be;
    logic [31:0] rd_out;
    logic        rd_en_out, stall_req, bus_err;
    logic [4:0]  rd_addr_out;
`ifdef MEM_MISALIGN_EXC_EN
    logic        misalign_exc;
`endif

    mem_access #(.XLEN(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in),
        .funct3_in(funct3_in), .addr_in(addr_in), .wdata_in(wdata_in), .rd_in(rd_in),
        .rd_en_in(rd_en_in), .rd_addr_in(rd_addr_in), .dbus_req(dbus_req), .dbus_we(dbus_we),
        .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .dbus_ack(dbus_ack),
        .dbus_rdata(dbus_rdata), .rd_out(rd_out), .rd_en_out(rd_en_out), .rd_addr_out(rd_addr_out),
        .stall_req(stall_req), .bus_err(bus_err)
`ifdef MEM_MISALIGN_EXC_EN
        , .misalign_exc(misalign_exc)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Observations of the last transaction driven by mem_op.
    int          o_stalls, o_req;
    logic [31:0] o_addr, o_wdata, o_rd;
    logic [3:0]  o_be;
    logic [4:0]  o_rdaddr;
    logic        o_we, o_en, o_err, o_stable, o_resp_stall, o_accept_en, o_err_after;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        int unsigned sh;
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: begin
                sh = (a % 4) * 8;
                v = (w >> sh) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end
            3'd1, 3'd5: begin
                sh = ((a / 2) % 2) * 16;
                v = (w >> sh) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd0) return 4'b0001 << (a % 4);
        if (f3 == 3'd1) return ((a / 2) % 2 == 1) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] w);
        if (f3 == 3'd0) return (w & 32'hFF) * 32'h0101_0101;
        if (f3 == 3'd1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    // Called just after a rising edge; acts as the bus slave, acking after `waits` wait cycles (-1: never).
    task automatic mem_op(input logic ld, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w,
                          input logic [31:0] rdata, input logic [4:0] ra, input int waits);
        int n;
        valid_in = 1'b1; mem_rd_in = ld; mem_wr_in = ~ld; funct3_in = f3; addr_in = a;
        wdata_in = w; rd_in = $urandom; rd_en_in = 1'b1; rd_addr_in = ra;
        #1;
        o_stalls = int'(stall_req); o_accept_en = rd_en_out; o_req = 0; o_stable = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (dbus_req === 1'b1 && n < 400) begin
            o_stalls += int'(stall_req);
            if (o_req == 0) begin
                o_addr = dbus_addr; o_wdata = dbus_wdata; o_be = dbus_be; o_we = dbus_we;
            end else if ({dbus_addr, dbus_wdata, dbus_be, dbus_we} !== {o_addr, o_wdata, o_be, o_we}) begin
                o_stable = 1'b0;
            end
            o_req++;
            if (waits >= 0 && o_req == waits + 1) begin
                dbus_ack = 1'b1; dbus_rdata = rdata;
            end
            @(posedge clk); #1;
            dbus_ack = 1'b0; dbus_rdata = $urandom;
            n++;
        end
        checks++;
        if (n >= 400) begin
            failures++; $display("FAIL mem_op_budget got=%0d cycles exp=<400", n);
        end
        o_resp_stall = stall_req; o_rd = rd_out; o_en = rd_en_out; o_rdaddr = rd_addr_out; o_err = bus_err;
        @(posedge clk); #1;
        o_err_after = bus_err;
        valid_in = 1'b0; mem_rd_in = 1'b0; mem_wr_in = 1'b0;
    endtask

    task automatic test_reset();
        valid_in = 1'b1; mem_rd_in = 1'b1; funct3_in = 3'd2; rd_in = 32'hDEAD_BEEF;
        rd_en_in = 1'b1; rd_addr_in = 5'd9; addr_in = 32'h40;
        @(posedge clk); #1;
        checks++;
        if ({dbus_req, dbus_we, dbus_be, stall_req, rd_en_out, bus_err} !== 9'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0", {dbus_req, dbus_we, dbus_be, stall_req, rd_en_out, bus_err});
        end
        checks++;
        if ({dbus_addr, dbus_wdata, rd_out, rd_addr_out} !== '0) begin
            failures++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", dbus_addr, dbus_wdata, rd_out, rd_addr_out);
        end
        valid_in = 1'b0; mem_rd_in = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_passthrough();
        valid_in = 1'b1; mem_rd_in = 1'b0; mem_wr_in = 1'b0;
        rd_in = 32'h1234; rd_en_in = 1'b1; rd_addr_in = 5'd5;
        #1;
        checks++;
        if ({rd_out, rd_en_out, rd_addr_out, stall_req} !== {32'h1234, 1'b1, 5'd5, 1'b0}) begin
            failures++; $display("FAIL alu_pass got=%h,%b,%0d,%b exp=1234,1,5,0", rd_out, rd_en_out, rd_addr_out, stall_req);
        end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] v;
            logic [4:0]  ra;
            logic        en;
            v = $urandom; ra = 5'($urandom); en = 1'($urandom);
            valid_in = 1'($urandom); mem_rd_in = ~valid_in;
            rd_in = v; rd_addr_in = ra; rd_en_in = en;
            #1;
            checks++;
            if ({rd_out, rd_en_out, rd_addr_out, stall_req} !== {v, en, ra, 1'b0}) begin
                failures++; $display("FAIL pass_rand got=%h,%b,%0d,%b exp=%h,%b,%0d,0", rd_out, rd_en_out, rd_addr_out, stall_req, v, en, ra);
            end
            @(posedge clk); #1;
            checks++;
            if (dbus_req !== 1'b0) begin
                failures++; $display("FAIL pass_no_req got=%b exp=0", dbus_req);
            end
        end
        valid_in = 1'b0; mem_rd_in = 1'b0;
    endtask

    task automatic test_load_byte();
        mem_op(1'b1, 3'd0, 32'h103, 32'h0, 32'h80FF_FF00, 5'd11, 0);
        checks++;
        if (o_stalls !== 2 || o_resp_stall !== 1'b0) begin
            failures++; $display("FAIL lb_stalls got=%0d,%b exp=2,0", o_stalls, o_resp_stall);
        end
        checks++;
        if (o_addr !== 32'h100 || o_we !== 1'b0) begin
            failures++; $display("FAIL lb_bus got=%h,%b exp=100,0", o_addr, o_we);
        end
        checks++;
        if ({o_rd, o_en, o_rdaddr} !== {32'hFFFF_FF80, 1'b1, 5'd11}) begin
            failures++; $display("FAIL lb_result got=%h,%b,%0d exp=ffffff80,1,11", o_rd, o_en, o_rdaddr);
        end
        checks++;
        if (o_accept_en !== 1'b0) begin
            failures++; $display("FAIL lb_accept_en got=%b exp=0", o_accept_en);
        end
    endtask

    task automatic test_store_half();
        mem_op(1'b0, 3'd1, 32'h202, 32'hABCD_1234, 32'h0, 5'd3, 3);
        checks++;
        if ({o_be, o_wdata, o_we, o_addr} !== {4'b1100, 32'h1234_1234, 1'b1, 32'h200}) begin
            failures++; $display("FAIL sh_bus got=%b,%h,%b,%h exp=1100,12341234,1,200", o_be, o_wdata, o_we, o_addr);
        end
        checks++;
        if (o_stalls !== 5 || o_req !== 4 || o_stable !== 1'b1) begin
            failures++; $display("FAIL sh_timing got=%0d,%0d,%b exp=5,4,1", o_stalls, o_req, o_stable);
        end
        checks++;
        if (o_en !== 1'b0 || o_err !== 1'b0) begin
            failures++; $display("FAIL sh_resp got=%b,%b exp=0,0", o_en, o_err);
        end
    endtask

    task automatic test_timeout();
        mem_op(1'b1, 3'd2, 32'h300, 32'h0, 32'h0, 5'd7, -1);
        checks++;
        if (o_req !== TMO || o_stalls !== TMO + 1) begin
            failures++; $display("FAIL tmo_cycles got=%0d,%0d exp=%0d,%0d", o_req, o_stalls, TMO, TMO + 1);
        end
        checks++;
        if ({o_err, o_en, o_resp_stall, o_err_after} !== 4'b1000) begin
            failures++; $display("FAIL tmo_resp got=%b exp=1000", {o_err, o_en, o_resp_stall, o_err_after});
        end
    endtask

    task automatic test_illegal();
        logic [3:0] ops [3];
        ops = '{4'b1_011, 4'b1_110, 4'b0_100};
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1; mem_rd_in = ops[i][3]; mem_wr_in = ~ops[i][3];
            funct3_in = ops[i][2:0]; addr_in = 32'h500; rd_en_in = 1'b1;
            #1;
            checks++;
            if (stall_req !== 1'b0 || rd_en_out !== 1'b0) begin
                failures++; $display("FAIL illegal_f3 got=%b,%b exp=0,0 op=%b", stall_req, rd_en_out, ops[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (dbus_req !== 1'b0 || stall_req !== 1'b0) begin
                failures++; $display("FAIL illegal_no_req got=%b,%b exp=0,0", dbus_req, stall_req);
            end
        end
        valid_in = 1'b0; mem_rd_in = 1'b0; mem_wr_in = 1'b0;
    endtask

    task automatic test_align();
`ifdef MEM_MISALIGN_EXC_EN
        logic [3:0] ops [3];
        logic [31:0] adr [3];
        ops = '{4'b1_010, 4'b1_001, 4'b0_010};
        adr = '{32'h102, 32'h101, 32'h103};
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1; mem_rd_in = ops[i][3]; mem_wr_in = ~ops[i][3];
            funct3_in = ops[i][2:0]; addr_in = adr[i]; rd_en_in = 1'b1;
            #1;
            checks++;
            if ({misalign_exc, stall_req, rd_en_out} !== 3'b100) begin
                failures++; $display("FAIL misalign got=%b exp=100", {misalign_exc, stall_req, rd_en_out});
            end
            @(posedge clk); #1;
            checks++;
            if (dbus_req !== 1'b0) begin
                failures++; $display("FAIL misalign_no_req got=%b exp=0", dbus_req);
            end
        end
        valid_in = 1'b0; mem_rd_in = 1'b0; mem_wr_in = 1'b0;
`else
        logic [31:0] r;
        r = $urandom;
        mem_op(1'b1, 3'd2, 32'h102, 32'h0, r, 5'd20, 1);
        checks++;
        if ({o_addr, o_rd, o_en} !== {32'h100, r, 1'b1}) begin
            failures++; $display("FAIL lw_forcealign got=%h,%h,%b exp=100,%h,1", o_addr, o_rd, o_en, r);
        end
`endif
    endtask

    task automatic test_reset_mid_req();
        logic [31:0] r;
        valid_in = 1'b1; mem_rd_in = 1'b1; funct3_in = 3'd2; addr_in = 32'h40; rd_en_in = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (dbus_req !== 1'b1) begin
            failures++; $display("FAIL rst_mid_pre got=%b exp=1", dbus_req);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (dbus_req !== 1'b0 || stall_req !== 1'b0) begin
            failures++; $display("FAIL rst_mid_drop got=%b,%b exp=0,0", dbus_req, stall_req);
        end
        valid_in = 1'b0; mem_rd_in = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        rd_in = 32'h55; rd_en_in = 1'b0; dbus_ack = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dbus_ack = 1'b0;
        checks++;
        if ({dbus_req, stall_req, rd_en_out, rd_out} !== {3'b000, 32'h55}) begin
            failures++; $display("FAIL rst_stray_ack got=%b,%b,%b,%h exp=0,0,0,55", dbus_req, stall_req, rd_en_out, rd_out);
        end
        r = $urandom;
        mem_op(1'b1, 3'd5, 32'h42, 32'h0, r, 5'd4, 2);
        checks++;
        if ({o_rd, o_en, o_stalls} !== {{16'h0, r[31:16]}, 1'b1, 32'd4}) begin
            failures++; $display("FAIL rst_after_op got=%h,%b,%0d exp=%h,1,4", o_rd, o_en, o_stalls, {16'h0, r[31:16]});
        end
    endtask

    task automatic test_random();
        logic [2:0] lf [5];
        lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < 24; i++) begin
            logic        ld;
            logic [2:0]  f3;
            logic [31:0] a, w, r;
            logic [4:0]  ra;
            int          wt;
            ld = 1'($urandom); a = $urandom; w = $urandom; r = $urandom; ra = 5'($urandom);
            wt = $urandom_range(0, 4);
            f3 = ld ? lf[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
`ifdef MEM_MISALIGN_EXC_EN
            if (f3 == 3'd1 || f3 == 3'd5) a[0] = 1'b0;
            if (f3 == 3'd2) a[1:0] = 2'b00;
`endif
            mem_op(ld, f3, a, w, r, ra, wt);
            checks++;
            if (o_stalls !== wt + 2 || o_resp_stall !== 1'b0 || o_stable !== 1'b1) begin
                failures++; $display("FAIL rnd_timing got=%0d,%b,%b exp=%0d,0,1", o_stalls, o_resp_stall, o_stable, wt + 2);
            end
            checks++;
            if (o_addr !== (a & 32'hFFFF_FFFC) || o_we !== ~ld) begin
                failures++; $display("FAIL rnd_addr got=%h,%b exp=%h,%b", o_addr, o_we, a & 32'hFFFF_FFFC, ~ld);
            end
            checks++;
            if (ld) begin
                if ({o_rd, o_en, o_rdaddr, o_err} !== {ref_load(f3, a, r), 1'b1, ra, 1'b0}) begin
                    failures++; $display("FAIL rnd_load got=%h,%b,%0d,%b exp=%h,1,%0d,0 f3=%0d a=%h", o_rd, o_en, o_rdaddr, o_err, ref_load(f3, a, r), ra, f3, a);
                end
            end else begin
                if ({o_be, o_wdata, o_en, o_err} !== {ref_be(f3, a), ref_wdata(f3, w), 2'b00}) begin
                    failures++; $display("FAIL rnd_store got=%b,%h,%b,%b exp=%b,%h,0,0 f3=%0d a=%h", o_be, o_wdata, o_en, o_err, ref_be(f3, a), ref_wdata(f3, w), f3, a);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_byte();
        test_store_half();
        test_timeout();
        test_illegal();
        test_align();
        test_reset_mid_req();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
